// File: rtl/quad_encoder_gen.sv
// Quadrature step generator: queues same-direction step commands and plays each
// one as a Gray-coded rota/rotb sequence, holding every phase for HOLD clocks.
module quad_encoder_gen #(
  parameter int HOLD     = 4,
  parameter int MAX_PEND = 15,
  parameter int PEND_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic              cmd_dir,
  output logic              cmd_ready,
  output logic              rota,
  output logic              rotb,
  output logic              busy,
  output logic              step_done,
  output logic [PEND_W-1:0] pending
);

  localparam int CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [2:0] {IDLE, PH1, PH2, PH3, PH4} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             queued_dir, active_dir, dir_nxt;
  logic             accept, dequeue, expire;
  logic             a_nxt, b_nxt, done_nxt;

  // A direction change is held off until the queue drains, so the queue only
  // ever holds steps of one direction and needs just one direction bit.
  assign cmd_ready = (pending < PEND_W'(MAX_PEND)) &&
                     ((pending == '0) || (cmd_dir == queued_dir));
  assign accept    = cmd_valid && cmd_ready;
  assign expire    = (cnt == CNT_W'(HOLD - 1));
  assign busy      = (state != IDLE) || (pending != '0);

  always_comb begin
    state_nxt = state;
    dequeue   = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: if (pending != '0) begin
        state_nxt = PH1;
        dequeue   = 1'b1;
      end
      PH1: if (expire) state_nxt = PH2;
      PH2: if (expire) state_nxt = PH3;
      PH3: if (expire) begin
        state_nxt = PH4;
        done_nxt  = 1'b1;
      end
      PH4: if (expire) begin
        if (pending != '0) begin
          state_nxt = PH1;
          dequeue   = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    dir_nxt = dequeue ? queued_dir : active_dir;

    if ((state_nxt != state) || (state_nxt == IDLE)) cnt_nxt = '0;
    else                                             cnt_nxt = cnt + 1'b1;

    // Outputs decode the next state so rota/rotb come straight from flops.
    case (state_nxt)
      PH1:     {a_nxt, b_nxt} = dir_nxt ? 2'b10 : 2'b01;
      PH2:     {a_nxt, b_nxt} = 2'b11;
      PH3:     {a_nxt, b_nxt} = dir_nxt ? 2'b01 : 2'b10;
      default: {a_nxt, b_nxt} = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      pending    <= '0;
      queued_dir <= 1'b0;
      active_dir <= 1'b0;
      rota       <= 1'b0;
      rotb       <= 1'b0;
      step_done  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      pending    <= pending + PEND_W'(accept) - PEND_W'(dequeue);
      active_dir <= dir_nxt;
      rota       <= a_nxt;
      rotb       <= b_nxt;
      step_done  <= done_nxt;
      if (accept) queued_dir <= cmd_dir;
    end
  end

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Bench for quad_encoder_gen: directed scenarios plus random traffic, all
// compared against a step-timeline reference model.
module tb_quad_encoder_gen;
  localparam int HOLD = 4, MAX_PEND = 15, PEND_W = 4;

  logic clk = 0, reset = 0, cmd_valid = 0, cmd_dir = 0;
  logic cmd_ready, rota, rotb, busy, step_done;
  logic [PEND_W-1:0] pending;

  quad_encoder_gen #(.HOLD(HOLD), .MAX_PEND(MAX_PEND), .PEND_W(PEND_W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_dir(cmd_dir),
    .cmd_ready(cmd_ready), .rota(rota), .rotb(rotb), .busy(busy),
    .step_done(step_done), .pending(pending));

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0, n_fail = 0;
  int n_acc = 0, n_done = 0, ncyc = 0, peak = 0;
  bit dut_acc;
  logic [1:0] prev_ab = 2'b00;

  // Reference: a step is a timeline t = 0 .. 4*HOLD-1 and the waveform is a
  // lookup on t/HOLD; queued steps are a plain count.
  int pend_m = 0, t_m = 0;
  bit qdir_m = 0, dir_m = 0, run_m = 0, done_m = 0;

  function automatic bit ready_m(bit d);
    return (pend_m < MAX_PEND) && (pend_m == 0 || d == qdir_m);
  endfunction

  function automatic logic [1:0] ab_m();
    if (!run_m) return 2'b00;
    case (t_m / HOLD)
      0: return dir_m ? 2'b10 : 2'b01;
      1: return 2'b11;
      2: return dir_m ? 2'b01 : 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  task automatic model_edge(input bit rst, input bit v, input bit d);
    bit acc;
    if (rst) begin
      pend_m = 0; t_m = 0; qdir_m = 0; dir_m = 0; run_m = 0; done_m = 0;
      return;
    end
    acc = v && ready_m(d);
    if (run_m) begin
      t_m++;
      if (t_m == 4*HOLD) run_m = 0;
    end
    if (!run_m && pend_m > 0) begin
      run_m = 1; t_m = 0; dir_m = qdir_m; pend_m--;
    end
    if (acc) begin pend_m++; qdir_m = d; end
    done_m = run_m && (t_m == 3*HOLD);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, ncyc);
    end
  endtask

  // Drives one clock: inputs set at negedge, outputs compared at next negedge.
  task automatic cycle(input bit v, input bit d);
    cmd_valid = v; cmd_dir = d;
    #1;
    chk("cmd_ready", cmd_ready, ready_m(d));
    dut_acc = v && cmd_ready && !reset;
    if (dut_acc) n_acc++;
    @(posedge clk);
    model_edge(reset, v, d);
    @(negedge clk);
    ncyc++;
    chk("ab", {rota, rotb}, ab_m());
    chk("pending", pending, pend_m);
    chk("busy", busy, run_m || pend_m > 0);
    chk("step_done", step_done, done_m);
    if (!reset) chk("gray", ({rota, rotb} ^ prev_ab) == 2'b11, 0);
    prev_ab = {rota, rotb};
    if (step_done) n_done++;
    if (int'(pending) > peak) peak = int'(pending);
  endtask

  task automatic do_reset();
    reset = 1; cycle(0, 0); reset = 0;
  endtask

  initial begin
    int marks[$];
    bit hit, cur_dir;
    @(negedge clk);
    do_reset();
    chk("rst_ab", {rota, rotb}, 2'b00);
    chk("rst_pending", pending, 0);
    chk("rst_busy", busy, 0);
    #1 chk("rst_ready", cmd_ready, 1);

    // Single CW then single CCW step with absolute timing.
    for (int s = 0; s < 2; s++) begin
      bit d = (s == 0);
      cycle(1, d);
      for (int i = 1; i <= 17; i++) begin
        cycle(0, 0);
        if (i == 1)  chk("t_ph1", {rota, rotb}, d ? 2'b10 : 2'b01);
        if (i == 4)  chk("t_ph1_end", {rota, rotb}, d ? 2'b10 : 2'b01);
        if (i == 5)  chk("t_ph2", {rota, rotb}, 2'b11);
        if (i == 9)  chk("t_ph3", {rota, rotb}, d ? 2'b01 : 2'b10);
        if (i == 12) chk("t_nodone", step_done, 0);
        if (i == 13) begin chk("t_ph4", {rota, rotb}, 2'b00); chk("t_done", step_done, 1); end
        if (i == 14) chk("t_done_pulse", step_done, 0);
        if (i == 16) chk("t_busy_ph4", busy, 1);
        if (i == 17) chk("t_idle", busy, 0);
      end
    end

    // Three back-to-back CW steps.
    cycle(1, 1); cycle(1, 1); cycle(1, 1);
    chk("peak2", pending, 2);
    for (int i = 0; i < 80 && marks.size() < 3; i++) begin
      cycle(0, 0);
      if (step_done) marks.push_back(ncyc);
    end
    chk("b2b_count", marks.size(), 3);
    if (marks.size() == 3) begin
      chk("b2b_gap1", marks[1] - marks[0], 16);
      chk("b2b_gap2", marks[2] - marks[1], 16);
    end
    for (int i = 0; i < 40 && busy; i++) cycle(0, 0);
    chk("b2b_idle", busy, 0);

    // Hold valid for 20 cycles: saturation at MAX_PEND, no lost accepts.
    do_reset();
    n_acc = 0; n_done = 0; peak = 0;
    for (int i = 0; i < 20; i++) cycle(1, 1);
    chk("sat_peak", peak, MAX_PEND);
    for (int i = 0; i < 400 && busy; i++) cycle(0, 0);
    chk("sat_drain", busy, 0);
    chk("sat_done_eq_acc", n_done, n_acc);

    // Direction change refused until the queue empties.
    do_reset();
    cycle(1, 1); cycle(1, 1);
    hit = 0;
    for (int i = 0; i < 60 && !hit; i++) begin
      cycle(1, 0);
      hit = dut_acc;
      if (hit) chk("ccw_after_drain", pend_m, 1);
    end
    chk("ccw_accepted", hit, 1);
    for (int i = 0; i < 80 && busy; i++) cycle(0, 0);
    chk("ccw_idle", busy, 0);

    // Reset during PH2 with three queued.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0);
    chk("pre_rst_ab", {rota, rotb}, 2'b11);
    chk("pre_rst_pend", pending, 3);
    do_reset();
    chk("mid_rst_ab", {rota, rotb}, 2'b00);
    chk("mid_rst_pend", pending, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", step_done, 0);
    #1 chk("mid_rst_ready", cmd_ready, 1);

    // Random traffic.
    cur_dir = 1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(7) == 0) cur_dir = ~cur_dir;
      reset = ($urandom_range(299) == 0);
      cycle($urandom_range(1), cur_dir);
      reset = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
